filter_frame_ctrl: RTL and testbench

- Frame-synchronous sequencer that sits in front of the 3x3 window filters (median and others built on filter_core_3x3) and drives their `bypass` input.
- Measures active width and height of each input frame from the de/hs/vs timing.
- Validates the frame against the filter's limits and applies bypass changes only at the vertical-sync boundary, so a frame is never filtered half-on/half-off.
- Reports per-frame geometry and sticky error status to a register block.

---
 rtl/filter_frame_ctrl.sv | 153 +++++++++++++++
 tb/tb_filter_frame_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/filter_frame_ctrl.sv
// Frame-synchronous bypass sequencer for the 3x3 window filters.
// Measures each frame's active geometry from de/vs and checks it against
// the filter's line-buffer limits. Bypass changes are committed only at
// frame close, so a frame is never filtered half-on/half-off.
//
// Handshake: there is no valid/ready flow here. status_valid_o is a
// one-cycle strobe that marks the cycle in which frame_width_o and
// frame_height_o take new values. err_clr is a single-cycle request that
// clears the sticky flags, and a newly detected error in that same cycle wins.
module filter_frame_ctrl #(
    parameter int LINE_SIZE_MAX = 1024,
    parameter int CNT_WIDTH     = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 bypass_req,
    input  logic                 err_clr,
    input  logic                 de_i,
    input  logic                 hs_i,
    input  logic                 vs_i,
    output logic                 bypass_o,
    output logic [CNT_WIDTH-1:0] frame_width_o,
    output logic [CNT_WIDTH-1:0] frame_height_o,
    output logic                 status_valid_o,
    output logic                 err_size_o,
    output logic                 err_irreg_o,
    output logic [1:0]           state_o
);

    typedef enum logic [1:0] {
        WAIT_SYNC = 2'd0,
        ACTIVE    = 2'd1,
        BLANK     = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    state_t               state, state_nxt;
    logic                 de_d, vs_d;
    logic                 vs_rise, vs_fall, line_end;
    logic                 start, close;
    logic [CNT_WIDTH-1:0] pix_cnt, line_cnt, first_w;
    logic                 irreg;
    logic [CNT_WIDTH-1:0] line_cnt_upd, first_w_upd;
    logic                 irreg_upd;
    logic                 size_bad;
    logic                 hs_unused;

    // Horizontal sync carries no information the counters need.
    assign hs_unused = hs_i;

    assign vs_rise  = vs_i & ~vs_d;
    assign vs_fall  = ~vs_i & vs_d;
    assign line_end = ~de_i & de_d;
    assign state_o  = state;

    // Delayed copies of de/vs for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            de_d <= 1'b0;
            vs_d <= 1'b0;
        end else begin
            de_d <= de_i;
            vs_d <= vs_i;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= WAIT_SYNC;
        else     state <= state_nxt;
    end

    // Next-state logic; start opens a measurement, close ends one.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        close     = 1'b0;
        case (state)
            WAIT_SYNC: if (vs_rise) state_nxt = BLANK;
            BLANK: begin
                if (vs_fall) begin
                    state_nxt = ACTIVE;
                    start     = 1'b1;
                end
            end
            ACTIVE: begin
                if (vs_rise) begin
                    state_nxt = BLANK;
                    close     = 1'b1;
                end
            end
            default: state_nxt = WAIT_SYNC;
        endcase
    end

    // Line bookkeeping as it stands after this cycle, so a line ending on the
    // vs_rise cycle is already folded into the values used for frame close.
    always_comb begin
        line_cnt_upd = line_cnt;
        first_w_upd  = first_w;
        irreg_upd    = irreg;
        if (state == ACTIVE && line_end) begin
            if (line_cnt != CNT_MAX) line_cnt_upd = line_cnt + 1'b1;
            if (line_cnt == '0)           first_w_upd = pix_cnt;
            else if (pix_cnt != first_w)  irreg_upd   = 1'b1;
        end
        size_bad = (first_w_upd < CNT_WIDTH'(3))
                 | (32'(first_w_upd) > 32'(LINE_SIZE_MAX))
                 | (line_cnt_upd < CNT_WIDTH'(3));
    end

    // Pixel/line counters, saturating; idle outside ACTIVE.
    always_ff @(posedge clk) begin
        if (rst || start) begin
            pix_cnt  <= '0;
            line_cnt <= '0;
            first_w  <= '0;
            irreg    <= 1'b0;
        end else if (state == ACTIVE) begin
            if (de_i) begin
                if (pix_cnt != CNT_MAX) pix_cnt <= pix_cnt + 1'b1;
            end else if (line_end) begin
                pix_cnt <= '0;
            end
            line_cnt <= line_cnt_upd;
            first_w  <= first_w_upd;
            irreg    <= irreg_upd;
        end
    end

    // Frame-close reporting, bypass commit and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            bypass_o       <= 1'b1;
            frame_width_o  <= '0;
            frame_height_o <= '0;
            status_valid_o <= 1'b0;
            err_size_o     <= 1'b0;
            err_irreg_o    <= 1'b0;
        end else begin
            status_valid_o <= close;
            if (close) begin
                frame_width_o  <= first_w_upd;
                frame_height_o <= line_cnt_upd;
                bypass_o       <= bypass_req | size_bad | irreg_upd;
            end
            err_size_o  <= (err_size_o  & ~err_clr) | (close & size_bad);
            err_irreg_o <= (err_irreg_o & ~err_clr) | (close & irreg_upd);
        end
    end

endmodule

// File: tb/tb_filter_frame_ctrl.sv
// Directed bench for filter_frame_ctrl: a table of frame descriptors with
// hand-computed close results, plus hand sequences for reset and start-up.
module tb_filter_frame_ctrl;

    localparam int CW = 12;

    logic          clk = 1'b0;
    logic          rst, bypass_req, err_clr, de_i, hs_i, vs_i;
    logic          bypass_o, status_valid_o, err_size_o, err_irreg_o;
    logic [CW-1:0] frame_width_o, frame_height_o;
    logic [1:0]    state_o;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int w; int h; int short_line; int short_w;
        int req; int req_line; int coincide; int clr_close; int clr;
        int ew; int eh; int eb; int es; int ei;
    } vec_t;

    vec_t tbl [11];

    filter_frame_ctrl #(.LINE_SIZE_MAX(1024), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .bypass_req(bypass_req), .err_clr(err_clr),
        .de_i(de_i), .hs_i(hs_i), .vs_i(vs_i), .bypass_o(bypass_o),
        .frame_width_o(frame_width_o), .frame_height_o(frame_height_o),
        .status_valid_o(status_valid_o), .err_size_o(err_size_o),
        .err_irreg_o(err_irreg_o), .state_o(state_o)
    );

    // Clock.
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic de, input logic vs);
        @(posedge clk);
        #1;
        de_i = de;
        vs_i = vs;
        hs_i = ~de & ~vs;
    endtask

    // Plays one frame (vs must already be high) and checks its close.
    task automatic run_frame(input vec_t v, input int idx);
        logic bb;
        int   lw;
        bypass_req = v.req[0];
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        bb = bypass_o;
        for (int l = 0; l < v.h; l++) begin
            if (l == v.req_line) bypass_req = 1'b1;
            lw = (l == v.short_line) ? v.short_w : v.w;
            for (int p = 0; p < lw; p++) drive(1'b1, 1'b0);
            if (!(v.coincide != 0 && l == v.h - 1)) repeat (3) drive(1'b0, 1'b0);
        end
        @(negedge clk);
        chk($sformatf("f%0d_mid_bypass", idx), bypass_o, bb);
        chk($sformatf("f%0d_mid_state", idx), state_o, 1);
        drive(1'b0, 1'b1);
        if (v.clr_close != 0) err_clr = 1'b1;
        @(posedge clk);
        #1;
        err_clr = 1'b0;
        @(negedge clk);
        chk($sformatf("f%0d_status", idx), status_valid_o, 1);
        chk($sformatf("f%0d_width", idx), frame_width_o, v.ew);
        chk($sformatf("f%0d_height", idx), frame_height_o, v.eh);
        chk($sformatf("f%0d_bypass", idx), bypass_o, v.eb);
        chk($sformatf("f%0d_err_size", idx), err_size_o, v.es);
        chk($sformatf("f%0d_err_irreg", idx), err_irreg_o, v.ei);
        chk($sformatf("f%0d_state", idx), state_o, 2);
        drive(1'b0, 1'b1);
        @(negedge clk);
        chk($sformatf("f%0d_pulse_end", idx), status_valid_o, 0);
        drive(1'b0, 1'b1);
        drive(1'b0, 1'b1);
        if (v.clr != 0) begin
            @(posedge clk); #1; err_clr = 1'b1;
            @(posedge clk); #1; err_clr = 1'b0;
            @(negedge clk);
            chk($sformatf("f%0d_clr_size", idx), err_size_o, 0);
            chk($sformatf("f%0d_clr_irreg", idx), err_irreg_o, 0);
        end
    endtask

    initial begin
        //           w    h  sl sw req rl  co cc clr  ew   eh eb es ei
        tbl[0]  = '{8,    6, -1, 0, 0, -1, 0, 0, 0,  8,    6, 0, 0, 0};
        tbl[1]  = '{8,    6, -1, 0, 0, -1, 0, 0, 0,  8,    6, 0, 0, 0};
        tbl[2]  = '{8,    6, -1, 0, 0, -1, 0, 0, 0,  8,    6, 0, 0, 0};
        tbl[3]  = '{8,    6, -1, 0, 0,  3, 0, 0, 0,  8,    6, 1, 0, 0};
        tbl[4]  = '{1100, 6, -1, 0, 0, -1, 0, 0, 0,  1100, 6, 1, 1, 0};
        tbl[5]  = '{8,    6, -1, 0, 0, -1, 0, 0, 1,  8,    6, 0, 1, 0};
        tbl[6]  = '{8,    2, -1, 0, 0, -1, 0, 0, 1,  8,    2, 1, 1, 0};
        tbl[7]  = '{8,    4,  2, 7, 0, -1, 0, 0, 1,  8,    4, 1, 0, 1};
        tbl[8]  = '{8,    6, -1, 0, 0, -1, 1, 0, 0,  8,    6, 0, 0, 0};
        tbl[9]  = '{8,    2, -1, 0, 0, -1, 0, 1, 0,  8,    2, 1, 1, 0};
        tbl[10] = '{8,    6, -1, 0, 0, -1, 0, 0, 0,  8,    6, 0, 1, 0};

        rst = 1'b1; bypass_req = 1'b0; err_clr = 1'b0;
        de_i = 1'b0; hs_i = 1'b0; vs_i = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_bypass", bypass_o, 1);
        chk("rst_width", frame_width_o, 0);
        chk("rst_height", frame_height_o, 0);
        chk("rst_status", status_valid_o, 0);
        chk("rst_err_size", err_size_o, 0);
        chk("rst_err_irreg", err_irreg_o, 0);
        chk("rst_state", state_o, 0);

        // Partial frame after reset is discarded: no status pulse.
        repeat (2) begin
            for (int p = 0; p < 5; p++) drive(1'b1, 1'b0);
            repeat (3) drive(1'b0, 1'b0);
        end
        drive(1'b0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        chk("discard_state", state_o, 2);
        chk("discard_status", status_valid_o, 0);
        chk("discard_bypass", bypass_o, 1);
        repeat (3) drive(1'b0, 1'b1);

        for (int i = 0; i < 11; i++) run_frame(tbl[i], i);

        // Reset during line 2 of an active frame.
        drive(1'b0, 1'b0);
        drive(1'b0, 1'b0);
        for (int p = 0; p < 8; p++) drive(1'b1, 1'b0);
        repeat (3) drive(1'b0, 1'b0);
        for (int p = 0; p < 3; p++) drive(1'b1, 1'b0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("mrst_bypass", bypass_o, 1);
        chk("mrst_state", state_o, 0);
        chk("mrst_width", frame_width_o, 0);
        chk("mrst_height", frame_height_o, 0);
        chk("mrst_err_size", err_size_o, 0);
        chk("mrst_status", status_valid_o, 0);
        for (int p = 0; p < 5; p++) drive(1'b1, 1'b0);
        repeat (3) drive(1'b0, 1'b0);
        drive(1'b0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        chk("mrst_discard_state", state_o, 2);
        chk("mrst_discard_status", status_valid_o, 0);
        repeat (3) drive(1'b0, 1'b1);
        run_frame(tbl[0], 11);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
